// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : uart_pkg                                                     |
// | Purpose   : Shared types and constants for the uart receive path:        |
// |             receive state encoding, data width and bit-period helper.    |
// | Ports     : none (package)                                               |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Clock cycles per serial bit; integer truncation is intended.
  function automatic int unsigned cycles_per_bit(input int unsigned clock_frequency,
                                                 input int unsigned baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : sync_2ff                                                     |
// | Purpose   : Two-flop synchronizer for a single asynchronous input.       |
// |             Both flops reset to RESET_VALUE so an idle line does not     |
// |             look like an edge coming out of reset.                       |
// | Ports     : i_clock  - system clock                                      |
// |             i_reset  - synchronous active-high reset                     |
// |             i_async  - asynchronous input                                |
// |             o_sync   - synchronized output (stage 2)                     |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : uart_rx_deserializer                                         |
// | Purpose   : UART receive front end. Recovers 8N1 frames (LSB first) from |
// |             the asynchronous serial line and presents each byte in a     |
// |             single-entry ready/valid holding register. Framing and       |
// |             overrun errors are reported as one-cycle pulses.             |
// | Option    : define UART_RX_PARITY_EN for 8E1 frames and o_parity_error.  |
// | Ports     : i_clock         - system clock (CLOCK_FREQUENCY Hz)          |
// |             i_reset         - synchronous active-high reset              |
// |             i_rx            - asynchronous serial line, idle high        |
// |             o_data          - received byte, valid while o_data_valid    |
// |             o_data_valid    - byte held and available                    |
// |             i_data_ready    - consumer accepts byte on valid & ready     |
// |             o_framing_error - pulse: stop bit sampled low                |
// |             o_overrun       - pulse: completed byte dropped, holding full|
// |             o_parity_error  - pulse: parity mismatch (option only)       |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 100000000,
  parameter int unsigned BAUD_RATE       = 115200
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_valid,
  input  logic                 i_data_ready,
  output logic                 o_framing_error,
`ifdef UART_RX_PARITY_EN
  output logic                 o_parity_error,
`endif
  output logic                 o_overrun
);

  localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT);
  localparam int unsigned IDX_W          = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] C_BIT_RELOAD  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_RELOAD = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX    = IDX_W'(DATA_BITS - 1);

  generate
    if (CYCLES_PER_BIT < 4) begin : g_bad_bit_period
      $error("uart_rx_deserializer: CYCLES_PER_BIT must be at least 4");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------
  logic w_rx_s;

  sync_2ff #(
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_rx),
    .o_sync  (w_rx_s)
  );

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_framing_error;
  logic                 r_overrun;

  rx_state_t            w_state_next;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [IDX_W-1:0]     w_idx_next;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_load;
  logic                 w_framing_error;
  logic                 w_overrun;
  logic                 w_cnt_zero;
  logic                 w_parity_bad;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_error;
  logic w_par_next;
  logic w_parity_error;

  // Even parity: data bits plus parity bit must have an even number of ones.
  assign w_parity_bad = (^r_shift) ^ r_par_bit;
`else
  assign w_parity_bad = 1'b0;
`endif

  assign w_cnt_zero = (r_cnt == '0);

  // ---------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_idx_next      = r_idx;
    w_shift_next    = r_shift;
    w_load          = 1'b0;
    w_framing_error = 1'b0;
    w_overrun       = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_next      = r_par_bit;
    w_parity_error  = 1'b0;
`endif

    unique case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_cnt_next   = C_HALF_RELOAD;
          w_state_next = START;
        end
      end

      START: begin
        if (w_cnt_zero) begin
          // Mid start bit: a line already back high was only a glitch.
          if (w_rx_s) begin
            w_state_next = IDLE;
          end else begin
            w_cnt_next   = C_BIT_RELOAD;
            w_idx_next   = '0;
            w_state_next = DATA;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end

      DATA: begin
        if (w_cnt_zero) begin
          w_shift_next[r_idx] = w_rx_s;
          w_cnt_next          = C_BIT_RELOAD;
          w_idx_next          = r_idx + IDX_W'(1);
          if (r_idx == C_LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_cnt_zero) begin
          w_par_next   = w_rx_s;
          w_cnt_next   = C_BIT_RELOAD;
          w_state_next = STOP;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
`endif

      STOP: begin
        if (w_cnt_zero) begin
          // Returning to IDLE at mid stop bit lets back-to-back frames
          // resynchronize on the very next start edge.
          w_state_next = IDLE;
          if (!w_rx_s) begin
            w_framing_error = 1'b1;
            w_state_next    = BREAK;
          end else if (w_parity_bad) begin
`ifdef UART_RX_PARITY_EN
            w_parity_error = 1'b1;
`endif
          end else if (!r_valid || i_data_ready) begin
            w_load = 1'b1;
          end else begin
            w_overrun = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end

      BREAK: begin
        // A held-low line must not be mistaken for a stream of 0x00 frames.
        if (w_rx_s) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_shift         <= '0;
      r_data          <= '0;
      r_valid         <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit       <= 1'b0;
      r_parity_error  <= 1'b0;
`endif
    end else begin
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      r_idx           <= w_idx_next;
      r_shift         <= w_shift_next;
      r_framing_error <= w_framing_error;
      r_overrun       <= w_overrun;
`ifdef UART_RX_PARITY_EN
      r_par_bit       <= w_par_next;
      r_parity_error  <= w_parity_error;
`endif
      // A load on the same edge as a drain keeps valid high with the new byte.
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (i_data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data          = r_data;
  assign o_data_valid    = r_valid;
  assign o_framing_error = r_framing_error;
  assign o_overrun       = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign o_parity_error  = r_parity_error;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_uart_rx_deserializer                                      |
// | Purpose   : Self-checking bench for uart_rx_deserializer. Serial frames  |
// |             are driven bit by bit; expected bytes go into a queue and    |
// |             are compared when the DUT hands them over.                   |
// | Option    : UART_RX_PARITY_EN adds the 8E1 parity cases.                 |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_uart_rx_deserializer;

  localparam int unsigned CLK_FREQ = 3200000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;   // 32
  localparam int unsigned HALF     = CPB / 2;           // 16
`ifdef UART_RX_PARITY_EN
  localparam int unsigned LAT      = 2 + HALF + 10 * CPB;
`else
  localparam int unsigned LAT      = 2 + HALF + 9 * CPB;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       framing_error;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  always #5 clock = ~clock;

  uart_rx_deserializer #(
    .CLOCK_FREQUENCY (CLK_FREQ),
    .BAUD_RATE       (BAUD)
  ) dut (
    .i_clock         (clock),
    .i_reset         (reset),
    .i_rx            (rx),
    .o_data          (data),
    .o_data_valid    (data_valid),
    .i_data_ready    (data_ready),
    .o_framing_error (framing_error),
`ifdef UART_RX_PARITY_EN
    .o_parity_error  (parity_error),
`endif
    .o_overrun       (overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Cycle counter: number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int  rise_count = 0;
  int  rise_cyc   = 0;
  int  ferr_count = 0;
  int  ovr_count  = 0;
  int  perr_count = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr  = 1'b0;
  logic prev_ovr   = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic prev_perr  = 1'b0;
`endif

  always @(negedge clock) begin
    #1;
    if (data_valid && !prev_valid) begin
      rise_count++;
      rise_cyc = cyc;
    end
    if (framing_error) begin
      ferr_count++;
      check("ferr_width", {31'd0, prev_ferr}, 32'd0);
      check("ferr_with_load", {31'd0, data_valid && !prev_valid}, 32'd0);
    end
    if (overrun) begin
      ovr_count++;
      check("ovr_width", {31'd0, prev_ovr}, 32'd0);
    end
`ifdef UART_RX_PARITY_EN
    if (parity_error) begin
      perr_count++;
      check("perr_width", {31'd0, prev_perr}, 32'd0);
    end
    prev_perr = parity_error;
`endif
    if (data_valid && data_ready) begin
      if (exp_q.size() == 0)
        check("unexpected_byte", {31'd0, data_valid}, 32'd0);
      else
        check("rx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
    end
    prev_valid = data_valid;
    prev_ferr  = framing_error;
    prev_ovr   = overrun;
  end

  // ---------------------------------------------------------------------
  // Serial stimulus
  // ---------------------------------------------------------------------
  int start_cyc = 0;

  task automatic drive_bit(input logic b, input int unsigned n);
    rx = b;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    start_cyc = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_v, CPB);
`else
    if (par_v) begin end
`endif
    drive_bit(stop_v, CPB);
  endtask

  int r0, f0, o0, p0;

  task automatic snap();
    r0 = rise_count; f0 = ferr_count; o0 = ovr_count; p0 = perr_count;
  endtask

  initial begin
    repeat (4) @(negedge clock);
    check("rst_data",  {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_ferr",  {31'd0, framing_error}, 32'd0);
    check("rst_ovr",   {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    drive_bit(1'b1, 2 * CPB);

    // Single byte, latency and one-cycle valid with ready high.
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    drive_bit(1'b1, CPB);
    check("a5_rise", rise_count - r0, 1);
    check("a5_latency", rise_cyc - (start_cyc + 1), LAT);
    check("a5_valid_low", {31'd0, data_valid}, 32'd0);
    check("a5_errors", (ferr_count - f0) + (ovr_count - o0) + (perr_count - p0), 0);

    // Back-to-back frames with no idle gap.
    snap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drive_bit(1'b1, 2 * CPB);
    check("b2b_rise", rise_count - r0, 2);
    check("b2b_ferr", ferr_count - f0, 0);
    check("b2b_q_empty", exp_q.size(), 0);

    // Overrun: consumer stalled while a second byte completes.
    snap();
    data_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, ^8'h11);
    send_frame(8'h22, 1'b1, ^8'h22);
    drive_bit(1'b1, CPB);
    check("ovr_count", ovr_count - o0, 1);
    check("ovr_hold_data", {24'd0, data}, 32'h11);
    check("ovr_hold_valid", {31'd0, data_valid}, 32'd1);
    data_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("ovr_drained", {31'd0, data_valid}, 32'd0);
    check("ovr_q_empty", exp_q.size(), 0);

    // Framing error, held break, then recovery.
    snap();
    send_frame(8'h3C, 1'b0, ^8'h3C);
    drive_bit(1'b0, 2000);
    check("fe_count", ferr_count - f0, 1);
    check("fe_no_valid", rise_count - r0, 0);
    drive_bit(1'b1, 2 * CPB);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    drive_bit(1'b1, CPB);
    check("fe_recover", rise_count - r0, 1);
    check("fe_total", ferr_count - f0, 1);

    // Short glitch is rejected at the start-bit check.
    snap();
    drive_bit(1'b0, HALF - 4);
    drive_bit(1'b1, 2 * CPB);
    check("glitch_valid", rise_count - r0, 0);
    check("glitch_errs", (ferr_count - f0) + (ovr_count - o0) + (perr_count - p0), 0);

    // Reset after bit 3 of a frame discards the partial byte.
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid_data", {24'd0, data}, 32'd0);
    check("rst_mid_valid", {31'd0, data_valid}, 32'd0);
    drive_bit(1'b1, 12 * CPB);
    check("rst_mid_no_out", rise_count - r0, 0);
    check("rst_mid_errs", (ferr_count - f0) + (ovr_count - o0) + (perr_count - p0), 0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    drive_bit(1'b1, CPB);
    check("c3_rise", rise_count - r0, 1);

`ifdef UART_RX_PARITY_EN
    snap();
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    drive_bit(1'b1, CPB);
    check("par_ok_rise", rise_count - r0, 1);
    check("par_ok_perr", perr_count - p0, 0);
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    drive_bit(1'b1, CPB);
    check("par_bad_perr", perr_count - p0, 1);
    check("par_bad_rise", rise_count - r0, 0);
    check("par_bad_ovr", ovr_count - o0, 0);
`endif

    check("final_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
